// File: rtl/sys_result_writer.sv
`default_nettype none
// ============================================================================
// Module  : sys_result_writer
// Brief   : Deskews the 2x2 systolic array bottom-edge outputs, pairs the two
//           columns into one UB row write and walks the UB address from a base.
// Revision: 1.0  initial release
// ============================================================================
module sys_result_writer #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int CNT_W  = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_in,
   input  logic [ADDR_W-1:0] base_addr_in,
   input  logic [CNT_W-1:0]  num_rows_in,
   input  logic [DATA_W-1:0] sys_data_in_1,
   input  logic              sys_valid_in_1,
   input  logic [DATA_W-1:0] sys_data_in_2,
   input  logic              sys_valid_in_2,
   output logic [ADDR_W-1:0] ub_wr_addr_out,
   output logic              ub_wr_addr_valid_out,
   output logic [DATA_W-1:0] ub_wr_data_out_1,
   output logic [DATA_W-1:0] ub_wr_data_out_2,
   output logic              ub_wr_valid_out_1,
   output logic              ub_wr_valid_out_2,
   output logic              busy_out,
   output logic              done_out,
   output logic              err_out
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COLLECT = 2'd1;
   localparam logic [1:0] S_DONE    = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  row_q, row_d;
   logic              pend_q, pend_d;
   logic [DATA_W-1:0] skew_q, skew_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wr_v1_q, wr_v1_d;
   logic              wr_v2_q, wr_v2_d;
   logic [DATA_W-1:0] wr_d1_q, wr_d1_d;
   logic [DATA_W-1:0] wr_d2_q, wr_d2_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic              start_ok;
   logic              in_collect;
   logic              row_wr;
   logic              stray;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         base_q  <= '0;
         cnt_q   <= '0;
         row_q   <= '0;
         pend_q  <= 1'b0;
         skew_q  <= '0;
         addr_q  <= '0;
         wr_v1_q <= 1'b0;
         wr_v2_q <= 1'b0;
         wr_d1_q <= '0;
         wr_d2_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         cnt_q   <= cnt_d;
         row_q   <= row_d;
         pend_q  <= pend_d;
         skew_q  <= skew_d;
         addr_q  <= addr_d;
         wr_v1_q <= wr_v1_d;
         wr_v2_q <= wr_v2_d;
         wr_d1_q <= wr_d1_d;
         wr_d2_q <= wr_d2_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   // Next state: COLLECT ends the cycle the last row write is on the port
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start_in) begin
               state_d = (num_rows_in == '0) ? S_DONE : S_COLLECT;
            end
         end
         S_COLLECT: begin
            if (wr_v1_q && (row_q == cnt_q)) begin
               state_d = S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath and registered outputs
   always_comb begin
      start_ok   = (state_q == S_IDLE) && start_in;
      in_collect = (state_q == S_COLLECT) && (row_q != cnt_q);
      row_wr     = in_collect && pend_q;
      stray      = in_collect && !pend_q && sys_valid_in_2;

      base_d  = base_q;
      cnt_d   = cnt_q;
      row_d   = row_q;
      pend_d  = 1'b0;
      skew_d  = skew_q;
      addr_d  = addr_q;
      wr_v1_d = 1'b0;
      wr_v2_d = 1'b0;
      wr_d1_d = wr_d1_q;
      wr_d2_d = wr_d2_q;
      err_d   = err_q;

      if (start_ok) begin
         base_d = base_addr_in;
         cnt_d  = num_rows_in;
         row_d  = '0;
         err_d  = 1'b0;
      end

      if (row_wr) begin
         addr_d  = base_q + (ADDR_W'(row_q) << 1);
         wr_v1_d = 1'b1;
         wr_v2_d = sys_valid_in_2;
         wr_d1_d = skew_q;
         row_d   = row_q + CNT_W'(1);
         if (sys_valid_in_2) begin
            wr_d2_d = sys_data_in_2;
         end else begin
            err_d = 1'b1;
         end
      end

      if (stray) begin
         err_d = 1'b1;
      end

      // Capture a new column-1 only while rows remain after this cycle's write
      if (in_collect && sys_valid_in_1 && (row_d != cnt_q)) begin
         skew_d = sys_data_in_1;
         pend_d = 1'b1;
      end

      busy_d = (state_d == S_COLLECT);
      done_d = (state_d == S_DONE);
   end

   assign ub_wr_addr_out       = addr_q;
   assign ub_wr_addr_valid_out = wr_v1_q;
   assign ub_wr_data_out_1     = wr_d1_q;
   assign ub_wr_data_out_2     = wr_d2_q;
   assign ub_wr_valid_out_1    = wr_v1_q;
   assign ub_wr_valid_out_2    = wr_v2_q;
   assign busy_out             = busy_q;
   assign done_out             = done_q;
   assign err_out              = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sys_result_writer.sv
`default_nettype none
// ============================================================================
// Module  : tb_sys_result_writer
// Brief   : Randomized and directed row-drain jobs checked cycle by cycle
//           against a row-level timing model of sys_result_writer.
// Revision: 1.0  initial release
// ============================================================================
module tb_sys_result_writer;

   localparam int NC = 64;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start_in = 1'b0;
   logic [15:0] base_addr_in = '0;
   logic [5:0]  num_rows_in = '0;
   logic [15:0] sys_data_in_1 = '0;
   logic        sys_valid_in_1 = 1'b0;
   logic [15:0] sys_data_in_2 = '0;
   logic        sys_valid_in_2 = 1'b0;
   logic [15:0] ub_wr_addr_out;
   logic        ub_wr_addr_valid_out;
   logic [15:0] ub_wr_data_out_1;
   logic [15:0] ub_wr_data_out_2;
   logic        ub_wr_valid_out_1;
   logic        ub_wr_valid_out_2;
   logic        busy_out;
   logic        done_out;
   logic        err_out;

   always #5 clk = ~clk;

   sys_result_writer #(.DATA_W(16), .ADDR_W(16), .CNT_W(6)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .start_in             (start_in),
      .base_addr_in         (base_addr_in),
      .num_rows_in          (num_rows_in),
      .sys_data_in_1        (sys_data_in_1),
      .sys_valid_in_1       (sys_valid_in_1),
      .sys_data_in_2        (sys_data_in_2),
      .sys_valid_in_2       (sys_valid_in_2),
      .ub_wr_addr_out       (ub_wr_addr_out),
      .ub_wr_addr_valid_out (ub_wr_addr_valid_out),
      .ub_wr_data_out_1     (ub_wr_data_out_1),
      .ub_wr_data_out_2     (ub_wr_data_out_2),
      .ub_wr_valid_out_1    (ub_wr_valid_out_1),
      .ub_wr_valid_out_2    (ub_wr_valid_out_2),
      .busy_out             (busy_out),
      .done_out             (done_out),
      .err_out              (err_out)
   );

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Row description of one job: column-1 cycle (relative to start), data, faults
   int          row_c[16];
   logic [15:0] row_d1[16];
   logic [15:0] row_d2[16];
   bit          row_miss[16];
   bit          row_stray[16];

   // Per-cycle stimulus and expected outputs of the current job
   bit          s_v1[NC], s_v2[NC], s_st[NC];
   logic [15:0] s_d1[NC], s_d2[NC], s_base[NC];
   logic [5:0]  s_n[NC];
   bit          e_v1[NC], e_v2[NC], e_busy[NC], e_done[NC], e_err[NC];
   logic [15:0] e_a[NC], e_d1[NC], e_d2[NC];
   bit          err_sticky = 1'b0;

   task automatic check_zero(input string tag);
      check({tag, "_addr"}, ub_wr_addr_out, 0);
      check({tag, "_addr_v"}, ub_wr_addr_valid_out, 0);
      check({tag, "_d1"}, ub_wr_data_out_1, 0);
      check({tag, "_d2"}, ub_wr_data_out_2, 0);
      check({tag, "_v1"}, ub_wr_valid_out_1, 0);
      check({tag, "_v2"}, ub_wr_valid_out_2, 0);
      check({tag, "_busy"}, busy_out, 0);
      check({tag, "_done"}, done_out, 0);
      check({tag, "_err"}, err_out, 0);
   endtask

   task automatic idle_noise(input int n);
      for (int j = 0; j < n; j++) begin
         start_in       = 1'b0;
         sys_valid_in_1 = 1'($urandom);
         sys_valid_in_2 = 1'($urandom);
         sys_data_in_1  = 16'($urandom);
         sys_data_in_2  = 16'($urandom);
         @(posedge clk); #1;
         check("idle_v1", ub_wr_valid_out_1, 0);
         check("idle_v2", ub_wr_valid_out_2, 0);
         check("idle_busy", busy_out, 0);
         check("idle_done", done_out, 0);
         check("idle_err", err_out, err_sticky);
      end
      sys_valid_in_1 = 1'b0;
      sys_valid_in_2 = 1'b0;
   endtask

   task automatic rand_rows(input int n);
      int c;
      c = 0;
      for (int k = 0; k < n; k++) begin
         c = ((k == 0) ? 1 : c + 1) + int'($urandom % 3);
         row_c[k]     = c;
         row_d1[k]    = 16'($urandom);
         row_d2[k]    = 16'($urandom);
         row_miss[k]  = ($urandom % 5) == 0;
         row_stray[k] = 1'b0;
      end
      for (int k = 0; k + 1 < n; k++) begin
         if (row_c[k+1] >= row_c[k] + 2 && ($urandom % 4) == 0) row_stray[k] = 1'b1;
      end
   endtask

   task automatic run_job(input int nrows, input logic [15:0] base, input bit bogus);
      int c, last, len, err_from, bs;
      for (int i = 0; i < NC; i++) begin
         s_v1[i] = 0; s_v2[i] = 0; s_st[i] = 0;
         s_d1[i] = 16'($urandom); s_d2[i] = 16'($urandom);
         s_base[i] = 16'($urandom); s_n[i] = 6'($urandom);
         e_v1[i] = 0; e_v2[i] = 0; e_busy[i] = 0; e_done[i] = 0; e_err[i] = 0;
         e_a[i] = '0; e_d1[i] = '0; e_d2[i] = '0;
      end
      s_st[0] = 1; s_base[0] = base; s_n[0] = 6'(nrows);
      err_from = NC + 10;
      last = 0;
      if (nrows == 0) begin
         e_done[1] = 1;
         len = 5;
         for (int j = 1; j <= 3; j++) begin
            s_v1[j] = 1'($urandom);
            s_v2[j] = 1'($urandom);
         end
      end else begin
         for (int k = 0; k < nrows; k++) begin
            c = row_c[k];
            s_v1[c] = 1; s_d1[c] = row_d1[k];
            if (!row_miss[k]) begin
               s_v2[c+1] = 1; s_d2[c+1] = row_d2[k];
            end else if (c + 2 < err_from) begin
               err_from = c + 2;
            end
            e_v1[c+2] = 1; e_v2[c+2] = !row_miss[k];
            e_a[c+2]  = base + 16'(2 * k);
            e_d1[c+2] = row_d1[k]; e_d2[c+2] = row_d2[k];
            if (row_stray[k]) begin
               s_v2[c+2] = 1;
               if (c + 3 < err_from) err_from = c + 3;
            end
         end
         last = row_c[nrows-1];
         for (int j = 1; j <= last + 2; j++) e_busy[j] = 1;
         e_done[last+3] = 1;
         len = last + 5;
      end
      if (bogus) begin
         bs = 1 + int'($urandom % ((nrows == 0) ? 1 : last + 3));
         s_st[bs] = 1;
         s_n[bs]  = 6'($urandom_range(1, 63));
      end
      for (int j = 1; j <= len; j++) e_err[j] = (j >= err_from);

      for (int j = 0; j < len; j++) begin
         start_in       = s_st[j];
         base_addr_in   = s_base[j];
         num_rows_in    = s_n[j];
         sys_valid_in_1 = s_v1[j];
         sys_data_in_1  = s_d1[j];
         sys_valid_in_2 = s_v2[j];
         sys_data_in_2  = s_d2[j];
         @(posedge clk); #1;
         check("wr_v1", ub_wr_valid_out_1, e_v1[j+1]);
         check("wr_v2", ub_wr_valid_out_2, e_v2[j+1]);
         check("addr_v", ub_wr_addr_valid_out, e_v1[j+1]);
         check("busy", busy_out, e_busy[j+1]);
         check("done", done_out, e_done[j+1]);
         check("err", err_out, e_err[j+1]);
         if (e_v1[j+1]) begin
            check("addr", ub_wr_addr_out, e_a[j+1]);
            check("data1", ub_wr_data_out_1, e_d1[j+1]);
         end
         if (e_v2[j+1]) check("data2", ub_wr_data_out_2, e_d2[j+1]);
      end
      start_in = 0; sys_valid_in_1 = 0; sys_valid_in_2 = 0;
      err_sticky = e_err[len];
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check_zero("reset");
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;

      // Basic two back-to-back rows
      row_c[0] = 1; row_d1[0] = 16'h0100; row_d2[0] = 16'h0200; row_miss[0] = 0; row_stray[0] = 0;
      row_c[1] = 2; row_d1[1] = 16'h0300; row_d2[1] = 16'h0400; row_miss[1] = 0; row_stray[1] = 0;
      run_job(2, 16'h0010, 0);
      idle_noise(2);

      // Zero rows
      run_job(0, 16'h1234, 0);
      idle_noise(2);

      // Missing column 2, sticky error, cleared by next start
      row_c[0] = 1; row_d1[0] = 16'h00AA; row_d2[0] = 16'h0000; row_miss[0] = 1; row_stray[0] = 0;
      run_job(1, 16'h0040, 0);
      idle_noise(2);

      // Address wrap
      row_c[0] = 1; row_d1[0] = 16'h1111; row_d2[0] = 16'h2222; row_miss[0] = 0; row_stray[0] = 0;
      row_c[1] = 3; row_d1[1] = 16'h3333; row_d2[1] = 16'h4444; row_miss[1] = 0; row_stray[1] = 0;
      run_job(2, 16'hFFFE, 0);
      idle_noise(2);

      // Reset mid-collect after two rows are written
      start_in = 1; base_addr_in = 16'h0400; num_rows_in = 6'd4;
      @(posedge clk); #1;
      start_in = 0;
      for (int j = 1; j <= 3; j++) begin
         sys_valid_in_1 = 1; sys_data_in_1 = 16'($urandom);
         sys_valid_in_2 = (j >= 2); sys_data_in_2 = 16'($urandom);
         @(posedge clk); #1;
      end
      check("pre_rst_wr", ub_wr_valid_out_1, 1);
      check("pre_rst_addr", ub_wr_addr_out, 16'h0402);
      sys_valid_in_1 = 0; sys_valid_in_2 = 1;
      #2 rst = 1'b0;
      #1 check_zero("mid_rst");
      sys_valid_in_2 = 0;
      repeat (2) @(posedge clk);
      #1 check_zero("held_rst");
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      err_sticky = 1'b0;
      idle_noise(3);
      row_c[0] = 2; row_d1[0] = 16'hBEEF; row_d2[0] = 16'hCAFE; row_miss[0] = 0; row_stray[0] = 0;
      run_job(1, 16'h0777, 0);

      // Ignored second start during a job
      idle_noise(3);
      rand_rows(4);
      run_job(4, 16'h2000, 1);

      // Randomized jobs
      for (int r = 0; r < 40; r++) begin
         int n;
         n = int'($urandom % 9);
         rand_rows(n);
         run_job(n, 16'($urandom), 1'($urandom));
         idle_noise(1 + int'($urandom % 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
